// File: rtl/lzc_norm_pipe_pkg.sv
// Shared ALU utility definitions for the leading/trailing-zero count and normalise pipeline.
package lzc_norm_pipe_pkg;

  // Bits examined by one lzc_group instance
  localparam int unsigned GRP = 8;

  // Count mode as carried on in_ctz
  typedef enum logic {
    MODE_CLZ = 1'b0,
    MODE_CTZ = 1'b1
  } mode_e;

  // Width of a count that must reach w (the all-zero case)
  function automatic int unsigned cw_of(int unsigned w);
    return $clog2(w + 1);
  endfunction

  // Number of groups needed to cover w bits
  function automatic int unsigned num_groups(int unsigned w);
    return (w + GRP - 1) / GRP;
  endfunction

  // Width of group g; only the top group can be partial
  function automatic int unsigned grp_width(int unsigned w, int unsigned g);
    return ((w - g * GRP) >= GRP) ? GRP : (w - g * GRP);
  endfunction

endpackage

// File: rtl/lzc_group.sv
// Zero count and nonzero flag for one group of up to 8 bits, CLZ or CTZ.
module lzc_group
  import lzc_norm_pipe_pkg::*;
#(
  parameter int unsigned GW = 8
) (
  input  logic [GW-1:0] i_data,
  input  logic          i_ctz,
  output logic [3:0]    o_cnt,
  output logic          o_nz
);

  // Priority scan: later hits overwrite, so CLZ settles on the highest set bit
  // and CTZ (scanned top-down) on the lowest; both reduce to count = GW-1-k.
  always_comb begin
    o_cnt = 4'(GW);
    o_nz  = |i_data;
    for (int unsigned k = 0; k < GW; k++) begin
      if (mode_e'(i_ctz) == MODE_CLZ) begin
        if (i_data[k]) o_cnt = 4'(GW - 1 - k);
      end else begin
        if (i_data[GW-1-k]) o_cnt = 4'(GW - 1 - k);
      end
    end
  end

endmodule

// File: rtl/lzc_norm_pipe.sv
// Elastic 1- or 2-stage leading/trailing zero counter with normalising shift.
module lzc_norm_pipe
  import lzc_norm_pipe_pkg::*;
#(
  parameter  int unsigned WIDTH  = 24,
  parameter  int unsigned STAGES = 2,
  localparam int unsigned CW     = cw_of(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_ctz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm
);

  localparam int unsigned NG = num_groups(WIDTH);

  logic [NG*4-1:0]  w_g_cnt;
  logic [NG-1:0]    w_g_nz;
  logic [NG*4-1:0]  w_s_cnt;
  logic [NG-1:0]    w_s_nz;
  logic [WIDTH-1:0] w_s_data;
  logic             w_s_ctz;
  logic             w_s_v;
  logic [CW-1:0]    w_f_count;
  logic             w_f_zero;
  logic [WIDTH-1:0] w_f_norm;
  logic             w_out_adv;
  logic             w_in_fire;

  logic             r_live;
  logic             r_ov;
  logic [CW-1:0]    r_count;
  logic             r_zero;
  logic [WIDTH-1:0] r_norm;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    localparam int unsigned GW = grp_width(WIDTH, g);
    lzc_group #(.GW(GW)) u_grp (
      .i_data (in_data[g*GRP +: GW]),
      .i_ctz  (in_ctz),
      .o_cnt  (w_g_cnt[g*4 +: 4]),
      .o_nz   (w_g_nz[g])
    );
  end

  assign w_out_adv = !r_ov || out_ready;
  assign w_in_fire = in_valid && in_ready && !flush;

  if (STAGES == 2) begin : g_two
    logic             r_s1_v;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_s1_ctz;
    logic [NG*4-1:0]  r_s1_cnt;
    logic [NG-1:0]    r_s1_nz;
    logic             w_s1_adv;

    assign w_s1_adv = !r_s1_v || w_out_adv;
    assign in_ready = r_live && w_s1_adv;

    // Stage-1 occupancy: killed by flush, refilled whenever it can move on
    always_ff @(posedge clock or negedge reset) begin
      if (!reset)        r_s1_v <= 1'b0;
      else if (flush)    r_s1_v <= 1'b0;
      else if (w_s1_adv) r_s1_v <= w_in_fire;
    end

    // Stage-1 datapath: group counts, operand and mode, loaded only on acceptance
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_s1_data <= '0;
        r_s1_ctz  <= 1'b0;
        r_s1_cnt  <= '0;
        r_s1_nz   <= '0;
      end else if (w_in_fire) begin
        r_s1_data <= in_data;
        r_s1_ctz  <= in_ctz;
        r_s1_cnt  <= w_g_cnt;
        r_s1_nz   <= w_g_nz;
      end
    end

    assign w_s_v    = r_s1_v;
    assign w_s_data = r_s1_data;
    assign w_s_ctz  = r_s1_ctz;
    assign w_s_cnt  = r_s1_cnt;
    assign w_s_nz   = r_s1_nz;
  end else begin : g_one
    assign in_ready = r_live && w_out_adv;
    assign w_s_v    = w_in_fire;
    assign w_s_data = in_data;
    assign w_s_ctz  = in_ctz;
    assign w_s_cnt  = w_g_cnt;
    assign w_s_nz   = w_g_nz;
  end

  // Pick the first nonzero group from the counting end, add its offset, then shift
  always_comb begin
    w_f_count = CW'(WIDTH);
    w_f_zero  = 1'b1;
    w_f_norm  = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      if (mode_e'(w_s_ctz) == MODE_CLZ) begin
        if (w_s_nz[k]) begin
          w_f_count = CW'(WIDTH - k * GRP - grp_width(WIDTH, k) + 32'(w_s_cnt[k*4 +: 4]));
          w_f_zero  = 1'b0;
        end
      end else begin
        if (w_s_nz[NG-1-k]) begin
          w_f_count = CW'((NG - 1 - k) * GRP + 32'(w_s_cnt[(NG-1-k)*4 +: 4]));
          w_f_zero  = 1'b0;
        end
      end
    end
    if (!w_f_zero) begin
      w_f_norm = (mode_e'(w_s_ctz) == MODE_CTZ) ? (w_s_data >> w_f_count)
                                                : (w_s_data << w_f_count);
    end
  end

  // Output occupancy and the post-reset enable that gates in_ready
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_live <= 1'b0;
      r_ov   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (flush)          r_ov <= 1'b0;
      else if (w_out_adv) r_ov <= w_s_v;
    end
  end

  // Output datapath: held while stalled, loaded only when a result enters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_zero  <= 1'b0;
      r_norm  <= '0;
    end else if (w_s_v && w_out_adv && !flush) begin
      r_count <= w_f_count;
      r_zero  <= w_f_zero;
      r_norm  <= w_f_norm;
    end
  end

  assign out_valid = r_ov;
  assign out_count = r_count;
  assign out_zero  = r_zero;
  assign out_norm  = r_norm;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Scoreboard bench for lzc_norm_pipe: stimulus pushes expectations, a monitor pops and compares.
module tb_lzc_norm_pipe;
  import lzc_norm_pipe_pkg::*;

  localparam int unsigned WIDTH  = 24;
  localparam int unsigned STAGES = 2;
  localparam int unsigned CW     = cw_of(WIDTH);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ctz = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    out_count;
  logic             out_zero;
  logic [WIDTH-1:0] out_norm;

  always #5 clock = ~clock;

  lzc_norm_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctz    (in_ctz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_zero  (out_zero),
    .out_norm  (out_norm)
  );

  typedef struct {
    int unsigned      cnt;
    bit               zero;
    logic [WIDTH-1:0] norm;
    int               t_in;
  } exp_t;

  exp_t q[$];
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  bit   lat_chk = 1'b0;
  bit   rand_bp = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference: locate the extreme set bit arithmetically, then shift
  function automatic exp_t model(logic [WIDTH-1:0] d, bit ctz);
    exp_t            e;
    longint unsigned x = 64'(d);
    int unsigned     p = 0;
    e.t_in = 0;
    if (x == 0) begin
      e.cnt = WIDTH; e.zero = 1'b1; e.norm = '0;
    end else if (!ctz) begin
      while ((x >> (p + 1)) != 0) p++;
      e.cnt = WIDTH - 1 - p; e.zero = 1'b0; e.norm = WIDTH'(x << e.cnt);
    end else begin
      while (((x >> p) & 64'd1) == 0) p++;
      e.cnt = p; e.zero = 1'b0; e.norm = WIDTH'(x >> p);
    end
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_data();
    logic [31:0] r = $urandom;
    int unsigned s = $urandom % (WIDTH + 1);
    logic [WIDTH-1:0] v = r[WIDTH-1:0];
    return v >> s;
  endfunction

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // Present one operand (called at posedge+1), push its expectation on acceptance
  task automatic send_exp(logic [WIDTH-1:0] d, bit ctz, exp_t e);
    int unsigned waited = 0;
    bit          acc    = 1'b0;
    in_data  = d;
    in_ctz   = ctz;
    in_valid = 1'b1;
    while (!acc) begin
      @(negedge clock);
      if (in_ready) begin
        acc    = 1'b1;
        e.t_in = cyc;
        q.push_back(e);
      end
      @(posedge clock); #1;
      if (!acc) begin
        waited++;
        if (waited > 200) begin
          n_chk++;
          $display("FAIL send_timeout in_ready=0 expected=1");
          acc = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send(logic [WIDTH-1:0] d, bit ctz);
    send_exp(d, ctz, model(d, ctz));
  endtask

  task automatic send_c(logic [WIDTH-1:0] d, bit ctz, int unsigned c, bit z, logic [WIDTH-1:0] n);
    exp_t e;
    e.cnt = c; e.zero = z; e.norm = n; e.t_in = 0;
    send_exp(d, ctz, e);
  endtask

  task automatic drain();
    int unsigned w = 0;
    while (q.size() != 0 && w < 300) begin
      @(posedge clock);
      w++;
    end
    chk("drain_queue_empty", q.size(), 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Monitor: every presented result must match the queue head; pop on transfer
  always @(negedge clock) begin
    if (reset && !flush && out_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output count=%0d zero=%0d norm=%0h expected=none",
                 out_count, out_zero, out_norm);
      end else begin
        n_chk++;
        if (int'(out_count) == int'(q[0].cnt) && out_zero == q[0].zero && out_norm == q[0].norm)
          n_pass++;
        else
          $display("FAIL result actual=%0d/%0d/%06h expected=%0d/%0d/%06h",
                   out_count, out_zero, out_norm, q[0].cnt, q[0].zero, q[0].norm);
        if (out_ready) begin
          if (lat_chk) chk("latency", longint'(cyc - q[0].t_in), STAGES);
          void'(q.pop_front());
        end
      end
    end
  end

  // Random backpressure on out_ready
  initial begin
    forever begin
      @(posedge clock); #1;
      if (rand_bp) out_ready = ($urandom % 4) != 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_norm", out_norm, 0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    #1 chk("ready_low_before_first_edge", in_ready, 0);
    @(posedge clock); #1;
    chk("ready_after_reset", in_ready, 1);

    // Directed values with latency checking, out_ready held high
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    send_c(24'h800000, 1'b0, 0,  1'b0, 24'h800000);
    send_c(24'h000001, 1'b0, 23, 1'b0, 24'h800000);
    send_c(24'h000000, 1'b0, 24, 1'b1, 24'h000000);
    send_c(24'h000000, 1'b1, 24, 1'b1, 24'h000000);
    send_c(24'h000010, 1'b1, 4,  1'b0, 24'h000001);
    send_c(24'h800000, 1'b1, 23, 1'b0, 24'h000001);
    send_c(24'h0000FF, 1'b0, 16, 1'b0, 24'hFF0000);
    send_c(24'h000100, 1'b1, 8,  1'b0, 24'h000001);
    drain();
    lat_chk = 1'b0;

    // Backpressure: out_ready low for 5 cycles with 4 back-to-back inputs
    out_ready = 1'b0;
    send(rnd_data(), 1'b0);
    send(rnd_data(), 1'b1);
    in_data  = 24'h000300;
    in_ctz   = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("bp_in_ready_low", in_ready, 0);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    send(24'h000300, 1'b0);
    send(24'h0A0000, 1'b1);
    drain();

    // Flush with both stages full and a concurrent in_valid
    out_ready = 1'b0;
    send(rnd_data(), 1'b0);
    send(rnd_data(), 1'b1);
    in_data  = 24'h123456;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clock); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) @(posedge clock);
    #1;

    // Flush while the input is actually accepted: that transfer must be dropped
    send(24'h00F000, 1'b0);
    in_data  = 24'h000F00;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clock); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush2_out_valid", out_valid, 0);
    chk("flush2_in_ready", in_ready, 1);
    repeat (5) @(posedge clock);
    #1;

    // Randomized traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom % 3) begin
        @(posedge clock); #1;
      end
      send(rnd_data(), 1'($urandom % 2));
    end
    rand_bp = 1'b0;
    @(posedge clock); #2;
    out_ready = 1'b1;
    @(posedge clock); #1;
    drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(rnd_data(), 1'b0);
    send(rnd_data(), 1'b1);
    chk("pre_reset_out_valid", out_valid, 1);
    #3 reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_count", out_count, 0);
    chk("midrst_out_zero", out_zero, 0);
    chk("midrst_out_norm", out_norm, 0);
    chk("midrst_in_ready", in_ready, 0);
    q.delete();
    @(posedge clock); #3;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_midrst", in_ready, 1);
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    send_c(24'h000001, 1'b0, 23, 1'b0, 24'h800000);
    drain();
    lat_chk = 1'b0;

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
